// File: rtl/e203_exu_flush_arb_pkg.sv
// e203_exu_flush_arb_pkg: shared state and source encodings for the flush arbiter
package e203_exu_flush_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;
  localparam logic SRC_EXCP = 1'b1;
  localparam logic SRC_BRCH = 1'b0;
endpackage

// File: rtl/e203_exu_flush_arb_if.sv
// e203_exu_flush_arb_if: flush source and IFU pipe-flush signals; pipe_flush_pc
// exists only with E203_FLUSH_ARB_PC_ADDER_EN.
interface e203_exu_flush_arb_if #(parameter int PC_SIZE = 32);
  logic               excp_flush_req;
  logic               excp_flush_ack;
  logic [PC_SIZE-1:0] excp_flush_add_op1;
  logic [PC_SIZE-1:0] excp_flush_add_op2;
  logic               brchmis_flush_req;
  logic               brchmis_flush_ack;
  logic [PC_SIZE-1:0] brchmis_flush_add_op1;
  logic [PC_SIZE-1:0] brchmis_flush_add_op2;
  logic               pipe_flush_req;
  logic               pipe_flush_ack;
  logic [PC_SIZE-1:0] pipe_flush_add_op1;
  logic [PC_SIZE-1:0] pipe_flush_add_op2;
  logic               pipe_flush_src;
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
  logic [PC_SIZE-1:0] pipe_flush_pc;
  modport master (
    output excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
    output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    input  excp_flush_ack, brchmis_flush_ack,
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_src, pipe_flush_pc,
    output pipe_flush_ack
  );
  modport slave (
    input  excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
    input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    output excp_flush_ack, brchmis_flush_ack,
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_src, pipe_flush_pc,
    input  pipe_flush_ack
  );
`else
  modport master (
    output excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
    output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    input  excp_flush_ack, brchmis_flush_ack,
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_src,
    output pipe_flush_ack
  );
  modport slave (
    input  excp_flush_req, excp_flush_add_op1, excp_flush_add_op2,
    input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    output excp_flush_ack, brchmis_flush_ack,
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_src,
    input  pipe_flush_ack
  );
`endif
endinterface

// File: rtl/e203_exu_flush_hold.sv
// e203_exu_flush_hold: load-enabled holding register for the accepted flush target;
// also holds op1+op2 when E203_FLUSH_ARB_PC_ADDER_EN is defined.
module e203_exu_flush_hold #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  input  logic         src_i,
  output logic [W-1:0] op1_o,
  output logic [W-1:0] op2_o,
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
  output logic [W-1:0] pc_o,
`endif
  output logic         src_o
);
  logic [W-1:0] op1_d, op1_q, op2_d, op2_q;
  logic         src_d, src_q;
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
  logic [W-1:0] pc_d, pc_q;
  always_comb pc_d = ld ? op1_i + op2_i : pc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  assign pc_o = pc_q;
`endif
  always_comb begin
    op1_d = ld ? op1_i : op1_q;
    op2_d = ld ? op2_i : op2_q;
    src_d = ld ? src_i : src_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      src_q <= 1'b0;
    end else begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      src_q <= src_d;
    end
  assign op1_o = op1_q;
  assign op2_o = op2_q;
  assign src_o = src_q;
endmodule

// File: rtl/e203_exu_flush_arb.sv
// e203_exu_flush_arb: exception-priority flush arbiter with IFU handshake and post-ack
// quiet window; E203_FLUSH_ARB_PC_ADDER_EN adds a registered pipe_flush_pc.
module e203_exu_flush_arb
  import e203_exu_flush_arb_pkg::*;
#(
  parameter int PC_SIZE   = 32,
  parameter int FLUSH_GAP = 2,
  parameter int GAP_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  e203_exu_flush_arb_if.slave    bus,
  output logic                   flush_busy
);
  state_e             state_d, state_q;
  logic [GAP_W-1:0]   cnt_d, cnt_q;
  logic               idle, excp_ack, brch_ack;
  assign idle     = state_q == IDLE;
  assign excp_ack = idle & bus.excp_flush_req;
  assign brch_ack = idle & bus.brchmis_flush_req & ~bus.excp_flush_req;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = (bus.excp_flush_req | bus.brchmis_flush_req) ? REQ : IDLE;
      REQ: if (bus.pipe_flush_ack) begin
        state_d = (FLUSH_GAP > 0) ? GAP : IDLE;
        cnt_d   = (FLUSH_GAP > 0) ? GAP_W'(FLUSH_GAP - 1) : '0;
      end
      GAP: begin
        state_d = (cnt_q == '0) ? IDLE : GAP;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  e203_exu_flush_hold #(.W(PC_SIZE)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (excp_ack | brch_ack),
    .op1_i (bus.excp_flush_req ? bus.excp_flush_add_op1 : bus.brchmis_flush_add_op1),
    .op2_i (bus.excp_flush_req ? bus.excp_flush_add_op2 : bus.brchmis_flush_add_op2),
    .src_i (bus.excp_flush_req ? SRC_EXCP : SRC_BRCH),
    .op1_o (bus.pipe_flush_add_op1),
    .op2_o (bus.pipe_flush_add_op2),
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
    .pc_o  (bus.pipe_flush_pc),
`endif
    .src_o (bus.pipe_flush_src)
  );
  assign bus.excp_flush_ack    = excp_ack;
  assign bus.brchmis_flush_ack = brch_ack;
  assign bus.pipe_flush_req    = state_q == REQ;
  assign flush_busy            = ~idle;
endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// tb_e203_exu_flush_arb: directed checks of arbitration, handshake, quiet window,
// zero-gap back-to-back and async reset; pc adder checked with E203_FLUSH_ARB_PC_ADDER_EN.
module tb_e203_exu_flush_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  e203_exu_flush_arb_if #(.PC_SIZE(32)) a();
  e203_exu_flush_arb_if #(.PC_SIZE(32)) b();
  e203_exu_flush_arb #(.PC_SIZE(32), .FLUSH_GAP(2), .GAP_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a), .flush_busy(busy_a));
  e203_exu_flush_arb #(.PC_SIZE(32), .FLUSH_GAP(0), .GAP_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b), .flush_busy(busy_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    {a.excp_flush_req, a.brchmis_flush_req, a.pipe_flush_ack} = '0;
    {b.excp_flush_req, b.brchmis_flush_req, b.pipe_flush_ack} = '0;
    {a.excp_flush_add_op1, a.excp_flush_add_op2, a.brchmis_flush_add_op1, a.brchmis_flush_add_op2} = '0;
    {b.excp_flush_add_op1, b.excp_flush_add_op2, b.brchmis_flush_add_op1, b.brchmis_flush_add_op2} = '0;
    #3;
    chk("rst_req", a.pipe_flush_req, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_op1", a.pipe_flush_add_op1, 0);
    chk("rst_src", a.pipe_flush_src, 0);
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
    chk("rst_pc", a.pipe_flush_pc, 0);
`endif
    #9 rst_n = 1'b1;
    tick;
    // branch only
    a.brchmis_flush_req = 1; a.brchmis_flush_add_op1 = 32'h8000_0100; a.brchmis_flush_add_op2 = 4;
    #1;
    chk("br_ack", a.brchmis_flush_ack, 1);
    chk("br_xack", a.excp_flush_ack, 0);
    tick;
    a.brchmis_flush_req = 0; #1;
    chk("br_req1", a.pipe_flush_req, 1);
    chk("br_op1", a.pipe_flush_add_op1, 32'h8000_0100);
    chk("br_op2", a.pipe_flush_add_op2, 4);
    chk("br_src", a.pipe_flush_src, 0);
    chk("br_busy", busy_a, 1);
    tick;
    chk("br_req2", a.pipe_flush_req, 1);
    tick;
    a.pipe_flush_ack = 1; #1;
    chk("br_req3", a.pipe_flush_req, 1);
    tick;
    a.pipe_flush_ack = 0; #1;
    chk("br_gap1_req", a.pipe_flush_req, 0);
    chk("br_gap1_busy", busy_a, 1);
    tick;
    chk("br_gap2_busy", busy_a, 1);
    tick;
    chk("br_idle", busy_a, 0);
    chk("br_hold_kept", a.pipe_flush_add_op1, 32'h8000_0100);
    // pipe ack while idle is ignored
    a.pipe_flush_ack = 1;
    tick;
    a.pipe_flush_ack = 0; #1;
    chk("ack_idle_busy", busy_a, 0);
    // simultaneous requests
    a.excp_flush_req = 1; a.excp_flush_add_op1 = 32'h8000_0200; a.excp_flush_add_op2 = 8;
    a.brchmis_flush_req = 1; a.brchmis_flush_add_op1 = 32'h8000_0300; a.brchmis_flush_add_op2 = 4;
    #1;
    chk("sim_xack", a.excp_flush_ack, 1);
    chk("sim_back", a.brchmis_flush_ack, 0);
    tick;
    a.excp_flush_req = 0; #1;
    chk("sim_src", a.pipe_flush_src, 1);
    chk("sim_op1", a.pipe_flush_add_op1, 32'h8000_0200);
    chk("sim_op2", a.pipe_flush_add_op2, 8);
    chk("sim_back_req", a.brchmis_flush_ack, 0);
    a.pipe_flush_ack = 1; #1;
    chk("sim_back_pack", a.brchmis_flush_ack, 0);
    tick;
    a.pipe_flush_ack = 0; #1;
    chk("sim_back_gap1", a.brchmis_flush_ack, 0);
    tick;
    chk("sim_back_gap2", a.brchmis_flush_ack, 0);
    tick;
    chk("sim_back_idle", a.brchmis_flush_ack, 1);
    tick;
    // exception arriving during REQ
    a.brchmis_flush_req = 0;
    a.excp_flush_req = 1; a.excp_flush_add_op1 = 32'hDEAD_0000; a.excp_flush_add_op2 = 32'h10;
    #1;
    chk("xr_src", a.pipe_flush_src, 0);
    chk("xr_op1", a.pipe_flush_add_op1, 32'h8000_0300);
    chk("xr_xack", a.excp_flush_ack, 0);
    tick;
    chk("xr_xack2", a.excp_flush_ack, 0);
    chk("xr_op1_kept", a.pipe_flush_add_op1, 32'h8000_0300);
    chk("xr_op2_kept", a.pipe_flush_add_op2, 4);
    a.pipe_flush_ack = 1;
    tick;
    a.pipe_flush_ack = 0; #1;
    chk("xr_gap1", a.excp_flush_ack, 0);
    tick;
    chk("xr_gap2", a.excp_flush_ack, 0);
    tick;
    chk("xr_idle", a.excp_flush_ack, 1);
    tick;
    a.excp_flush_req = 0; #1;
    chk("xr_req", a.pipe_flush_req, 1);
    chk("xr_src2", a.pipe_flush_src, 1);
    chk("xr_op1b", a.pipe_flush_add_op1, 32'hDEAD_0000);
    // async reset mid-REQ
    rst_n = 0; #1;
    chk("ar_req", a.pipe_flush_req, 0);
    chk("ar_busy", busy_a, 0);
    #3 rst_n = 1;
    tick;
    chk("ar_idle", busy_a, 0);
    chk("ar_op1", a.pipe_flush_add_op1, 0);
    chk("ar_op2", a.pipe_flush_add_op2, 0);
    chk("ar_src", a.pipe_flush_src, 0);
`ifdef E203_FLUSH_ARB_PC_ADDER_EN
    a.excp_flush_req = 1; a.excp_flush_add_op1 = 32'hFFFF_FFFE; a.excp_flush_add_op2 = 4;
    tick;
    a.excp_flush_req = 0; #1;
    chk("pc_wrap", a.pipe_flush_pc, 32'h0000_0002);
`endif
    // zero gap, back-to-back
    b.brchmis_flush_req = 1; b.brchmis_flush_add_op1 = 32'h100; b.brchmis_flush_add_op2 = 4;
    #1;
    chk("z_ack0", b.brchmis_flush_ack, 1);
    tick;
    b.brchmis_flush_add_op1 = 32'h200; #1;
    chk("z_req_k", b.pipe_flush_req, 1);
    chk("z_ack_k", b.brchmis_flush_ack, 0);
    chk("z_op1_k", b.pipe_flush_add_op1, 32'h100);
    b.pipe_flush_ack = 1;
    tick;
    b.pipe_flush_ack = 0; #1;
    chk("z_idle", busy_b, 0);
    chk("z_req_k1", b.pipe_flush_req, 0);
    chk("z_ack_k1", b.brchmis_flush_ack, 1);
    tick;
    b.brchmis_flush_req = 0; #1;
    chk("z_req_k2", b.pipe_flush_req, 1);
    chk("z_op1_k2", b.pipe_flush_add_op1, 32'h200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e203_exu_flush_arb.md
Name: e203_exu_flush_arb

Overview:
- Flush arbiter and sequencer between the commit-stage flush sources and the IFU pipe-flush interface.
- Two requesters:
  - the non-ALU exception/interrupt flush;
  - the branch-mispredict/fencei/mret/dret flush from the branch resolver.
- The winner's target operands are captured into a one-entry holding register and presented to the IFU until acknowledged.
- After each IFU ack, an optional quiet window blocks new flushes while the IFU refetches.

Parameters:
- PC_SIZE, 32, width of PC and flush add operands.
- FLUSH_GAP, 2, quiet cycles after an IFU ack before a new flush is accepted (0..15).
- GAP_W, 4, width of the gap counter; must hold FLUSH_GAP.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- excp_flush_req  in  1  exception/irq flush request
- excp_flush_ack  out  1  exception flush accepted this cycle
- excp_flush_add_op1  in  PC_SIZE  exception target operand 1
- excp_flush_add_op2  in  PC_SIZE  exception target operand 2
- brchmis_flush_req  in  1  branch-resolve flush request
- brchmis_flush_ack  out  1  branch flush accepted this cycle
- brchmis_flush_add_op1  in  PC_SIZE  branch target operand 1
- brchmis_flush_add_op2  in  PC_SIZE  branch target operand 2
- pipe_flush_req  out  1  flush request to IFU
- pipe_flush_ack  in  1  IFU accepts flush
- pipe_flush_add_op1  out  PC_SIZE  held operand 1
- pipe_flush_add_op2  out  PC_SIZE  held operand 2
- pipe_flush_src  out  1  held source: 1 = exception, 0 = branch
- flush_busy  out  1  arbiter not in IDLE

Behaviour:
- Reset values:
  - state = IDLE; gap counter = 0.
  - Holding operands = 0; pipe_flush_src = 0.
  - pipe_flush_req = 0; flush_busy = 0.
- States:
  - IDLE:
    - Acks are combinational.
    - excp_flush_ack = excp_flush_req.
    - brchmis_flush_ack = brchmis_flush_req & ~excp_flush_req. Exception has fixed priority; simultaneous requests grant exception only.
    - On any ack, capture the winner's op1, op2 and src. Go to REQ.
  - REQ:
    - pipe_flush_req = 1. Operands and src are stable until handshake.
    - Both source acks = 0, even if an exception arrives.
    - On pipe_flush_ack: go to GAP with counter = FLUSH_GAP-1 if FLUSH_GAP > 0, else IDLE.
  - GAP:
    - Source acks = 0; pipe_flush_req = 0.
    - Counter decrements each cycle. At 0, go to IDLE.
- Latency:
  - Source ack at cycle N; pipe_flush_req high from cycle N+1.
  - A new acceptance is possible no earlier than ack+1+FLUSH_GAP.
- Sources keep req asserted until acked. The block never drops an accepted flush.
- pipe_flush_ack outside REQ is ignored.
- The holding register is written only on acceptance. It is not cleared on completion.
- Asynchronous reset mid-REQ or mid-GAP:
  - Returns to IDLE immediately.
  - Pending flush is discarded; outputs go to reset values.
- flush_busy = (state != IDLE).

Optional Feature:
- Macro: E203_FLUSH_ARB_PC_ADDER_EN.
- When defined:
  - Add output pipe_flush_pc [PC_SIZE].
  - Equals op1 + op2, computed at capture and registered alongside the operands. Modulo 2^PC_SIZE; carry dropped.
  - Reset value 0.
- When undefined: port and adder are absent; IFU computes the target from op1/op2.

Decomposition:
- Shared package/defines:
  - state encoding constants IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2;
  - source encoding SRC_EXCP = 1, SRC_BRCH = 0.
- One natural sub-module: e203_exu_flush_hold, the enable-loaded holding register for op1/op2/src (and pc when the macro is set), using the codebase DFF primitive with asynchronous reset.
- FSM and gap counter stay in the top module.

Test Plan:
- Branch only: brchmis_flush_req with op1=0x8000_0100, op2=4; IFU acks 3 cycles later. Expect:
  - brchmis_flush_ack=1 in cycle 0;
  - pipe_flush_req cycles 1–3 with operands held;
  - GAP for 2 cycles, then IDLE.
- Simultaneous: both requests in one cycle, excp op1=0x8000_0200. Expect:
  - excp ack only; src=1, op1=0x8000_0200;
  - branch acked only after IFU ack + 2 gap cycles.
- Exception during REQ: branch held, exception raised. Expect:
  - excp_flush_ack=0 until after GAP;
  - held operands unchanged.
- FLUSH_GAP=0, back-to-back requests. Expect:
  - IFU ack in cycle k; IDLE in k+1;
  - second source ack in k+1; pipe_flush_req again in k+2.
- Reset in REQ: rst_n low mid-REQ. Expect:
  - pipe_flush_req=0 and flush_busy=0 asynchronously;
  - after release, IDLE with operands 0.
- Macro on: op1=0xFFFF_FFFE, op2=4. Expect pipe_flush_pc=0x0000_0002 (wrap).
